// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, and long-latency
// results queue in a small FIFO with WAW cancellation and starvation-driven stall.
module wb_port_arbiter #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                        i_aclk,
    input  logic                        i_areset_n,
    input  logic                        i_wb_regwrite,
    input  logic [$clog2(NUM_REGS)-1:0] i_wb_rdest,
    input  logic [DATA_SIZE-1:0]        i_wb_data,
    input  logic                        i_lu_valid,
    output logic                        o_lu_ready,
    input  logic [$clog2(NUM_REGS)-1:0] i_lu_rdest,
    input  logic [DATA_SIZE-1:0]        i_lu_data,
    output logic                        o_stall,
    output logic                        o_rf_we,
    output logic [$clog2(NUM_REGS)-1:0] o_rf_waddr,
    output logic [DATA_SIZE-1:0]        o_rf_wdata,
    output logic [NUM_REGS-1:0]         o_pending_mask
);

    localparam int unsigned AW     = $clog2(NUM_REGS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_C  = WAIT_W'(MAX_WAIT);

    typedef enum logic {NORMAL, STARVE} state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic [AW-1:0]        fifo_rdest [FIFO_DEPTH];
    logic [DATA_SIZE-1:0] fifo_data  [FIFO_DEPTH];
    logic                 fifo_kill  [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;

    logic [FIFO_DEPTH-1:0] slot_valid;
    logic                  wb_win, lu_win, head_valid, head_kill, head_killed_now;
    logic                  push, push_kill, pop;

    assign o_lu_ready = (count < DEPTH_C);
    assign o_stall    = (state_q == STARVE);

    assign wb_win     = i_wb_regwrite && (i_wb_rdest != '0);
    assign head_valid = (count != '0);
    assign head_kill  = fifo_kill[rd_ptr];
    assign lu_win     = !wb_win && head_valid && !head_kill;
    assign pop        = head_valid && (head_kill || lu_win);

    // Head counts as killed in the cycle a matching pipeline write lands, not only once the bit is stored.
    assign head_killed_now = head_valid &&
                             (head_kill || (wb_win && (fifo_rdest[rd_ptr] == i_wb_rdest)));

    // x0 results complete the handshake but are dropped here.
    assign push      = i_lu_valid && o_lu_ready && (i_lu_rdest != '0);
    assign push_kill = wb_win && (i_lu_rdest == i_wb_rdest);

    always_comb begin
        slot_valid = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            logic [PTR_W-1:0] off;
            off = PTR_W'(i) - rd_ptr;
            slot_valid[i] = (CNT_W'(off) < count);
        end
    end

    always_comb begin
        o_pending_mask = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_valid[i] && !fifo_kill[i])
                o_pending_mask[fifo_rdest[i]] = 1'b1;
        end
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rdest[i] <= '0;
                fifo_data[i]  <= '0;
                fifo_kill[i]  <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (slot_valid[i] && wb_win && (fifo_rdest[i] == i_wb_rdest))
                    fifo_kill[i] <= 1'b1;
            end
            if (push) begin
                fifo_rdest[wr_ptr] <= i_lu_rdest;
                fifo_data[wr_ptr]  <= i_lu_data;
                fifo_kill[wr_ptr]  <= push_kill;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_rf_we    <= 1'b0;
            o_rf_waddr <= '0;
            o_rf_wdata <= '0;
        end else begin
            o_rf_we <= wb_win || lu_win;
            if (wb_win) begin
                o_rf_waddr <= i_wb_rdest;
                o_rf_wdata <= i_wb_data;
            end else if (lu_win) begin
                o_rf_waddr <= fifo_rdest[rd_ptr];
                o_rf_wdata <= fifo_data[rd_ptr];
            end
        end
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q <= NORMAL;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (!head_valid || pop || head_killed_now)
            wait_d = '0;
        else if (wait_q != WAIT_C)
            wait_d = wait_q + 1'b1;
        case (state_q)
            NORMAL: if (wait_d == WAIT_C) state_d = STARVE;
            STARVE: if (!head_valid || pop || head_killed_now) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback stage;
  - long-latency units (divider, load-miss return), which deliver results through a small FIFO.
- Pipeline writes always have priority.
- Queued results get the port in idle slots. A starvation counter forces a pipeline bubble if a queued result waits too long.
- A stale queued write is cancelled when a younger pipeline write targets the same register (WAW).

Parameters:
- NUM_REGS, 32, architectural register count; address width is $clog2(NUM_REGS).
- DATA_SIZE, 32, register data width.
- FIFO_DEPTH, 2, long-latency result queue entries (power of 2, >=2).
- MAX_WAIT, 4, cycles a queued head may wait before o_stall asserts (>=1).

Ports:
- i_aclk  in  1  system clock
- i_areset_n  in  1  asynchronous active-low reset
- i_wb_regwrite  in  1  pipeline writeback wants the port this cycle
- i_wb_rdest  in  $clog2(NUM_REGS)  pipeline destination register
- i_wb_data  in  DATA_SIZE  pipeline write data
- i_lu_valid  in  1  long-latency result valid
- o_lu_ready  out  1  queue can accept a result
- i_lu_rdest  in  $clog2(NUM_REGS)  long-latency destination register
- i_lu_data  in  DATA_SIZE  long-latency result data
- o_stall  out  1  pipeline must present no regwrite (bubble) while high
- o_rf_we  out  1  register-file write enable (registered)
- o_rf_waddr  out  $clog2(NUM_REGS)  register-file write address (registered)
- o_rf_wdata  out  DATA_SIZE  register-file write data (registered)
- o_pending_mask  out  NUM_REGS  bit r set iff a live queued entry targets r

Behaviour:
- Reset is asynchronous: clock i_aclk, reset i_areset_n, asynchronous, active-low.
  - Reset values: o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0, o_stall=0, o_pending_mask=0, o_lu_ready=1.
  - Reset also clears the FIFO (count=0, pointers=0, all kill bits), wait_cnt=0 and state=NORMAL.
  - Reset mid-operation discards all queued entries.
- Port selection (combinational each cycle):
  - Winner is the pipeline if i_wb_regwrite && i_wb_rdest!=0.
  - Otherwise the winner is the FIFO head, if non-empty and not killed.
  - The winner's addr/data are registered onto o_rf_* at the next edge, so port latency is 1 cycle. o_rf_we=0 in cycles with no winner.
- Writes to x0:
  - A pipeline write to x0 never uses the port.
  - An accepted long-latency result to x0 is consumed (handshake completes) but is not enqueued.
- Handshake and queue:
  - o_lu_ready = (count < FIFO_DEPTH), derived from registered count only. No push when full, even if a pop occurs the same cycle.
  - Transfer occurs on i_lu_valid && o_lu_ready.
  - An entry enqueued at edge N is eligible from cycle N onward, so the earliest o_rf_we is at edge N+1: 2 cycles from a valid/ready handshake to o_rf_we.
  - Push and pop in the same cycle are allowed (count unchanged).
- Kill rule (WAW):
  - Any cycle with a pipeline port write to rd sets the kill bit of every queued entry whose rdest==rd.
  - A result being enqueued in the same cycle with rdest==rd is enqueued already killed.
  - A killed head is popped without writing, one per cycle, in any cycle. The next entry becomes head the following cycle.
- o_pending_mask is combinational from FIFO contents: OR of one-hot rdest over valid, non-killed entries.
- Starvation FSM, states NORMAL and STARVE:
  - wait_cnt clears when the FIFO is empty, when the head is popped, or when the head is killed.
  - Otherwise wait_cnt increments (saturating at MAX_WAIT) while a live head is denied the port.
  - NORMAL -> STARVE at the edge where wait_cnt reaches MAX_WAIT.
  - STARVE -> NORMAL at the edge where the head is popped or killed, or on reset.
  - o_stall = (state==STARVE).
  - The pipeline keeps priority even in STARVE; o_stall only requests the bubble.

Test Plan:
- Reset: assert i_areset_n=0 mid-queue with 2 entries -> all outputs at reset values asynchronously, o_lu_ready=1, o_pending_mask=0.
- Pipeline write: i_wb_regwrite=1, rdest=5, data=0xDEADBEEF at cycle T -> o_rf_we=1, waddr=5, wdata=0xDEADBEEF after edge T+1. A write to rdest=0 gives o_rf_we=0.
- LU write: handshake x7=0x00001234 at cycle T, pipeline idle -> o_pending_mask[7]=1 after edge T+1; o_rf_we=1, waddr=7 after edge T+2; mask bit clears.
- Starvation (MAX_WAIT=4): queue x3=0xA5, pipeline writes x1 every cycle -> o_stall rises after the 4th denied cycle. Drop i_wb_regwrite for one cycle -> x3 written, o_stall falls the next cycle.
- WAW kill: queue x9=0x11 while pipeline busy, then pipeline writes x9=0x22 -> only 0x22 reaches o_rf_wdata for x9; mask bit 9 clears; the killed entry is popped without o_rf_we.
- Full/x0: two handshakes (x4, x6) with pipeline busy -> o_lu_ready=0, a held i_lu_valid is not accepted. An LU result to x0 is accepted, never written, and leaves count unchanged.
